// File: rtl/fp16_fma_arbiter.sv
// Round-robin front end that shares one fixed-latency FP16 FMA among N
// requesters, returning results through credit-gated per-requester FIFOs.
module fp16_fma_arbiter #(
  parameter int N     = 4,
  parameter int LAT   = 4,
  parameter int DEPTH = 4,
  parameter int TAGQ  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               req_valid,
  output logic [N-1:0]               req_ready,
  input  logic [16*N-1:0]            req_a,
  input  logic [16*N-1:0]            req_b,
  input  logic [16*N-1:0]            req_c,
  output logic [N-1:0]               resp_valid,
  input  logic [N-1:0]               resp_ready,
  output logic [16*N-1:0]            resp_data,
  output logic                       fma_in_valid,
  output logic [15:0]                fma_a,
  output logic [15:0]                fma_b,
  output logic [15:0]                fma_c,
  input  logic                       fma_out_valid,
  input  logic [15:0]                fma_out,
  output logic [$clog2(TAGQ+1)-1:0]  inflight,
  output logic                       busy,
  output logic                       err_orphan
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(DEPTH+1);
  localparam int QW = $clog2(TAGQ+1);
  localparam int TP = (TAGQ > 1) ? $clog2(TAGQ) : 1;
  localparam int FP = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IW-1:0] ptr;
  logic [N-1:0]  elig;
  logic          gnt_any;
  logic [IW-1:0] gnt;
  logic          issue;

  logic          fv_q;
  logic [15:0]   fa_q, fb_q, fc_q;
  logic          err_q;
  logic [LAT-1:0] lat_sr;

  logic [IW-1:0] tq_mem [TAGQ];
  logic [TP-1:0] tq_wr, tq_rd;
  logic [QW-1:0] tq_cnt;
  logic [IW-1:0] tq_head;
  logic          tq_full;
  logic          tq_pop;

  logic [N-1:0]  f_wen;
  logic [N-1:0]  f_ren;

  // first eligible index at or above ptr, wrapping; lowest offset wins
  always_comb begin
    int j;
    j = 0;
    gnt_any = 1'b0;
    gnt = '0;
    for (int k = N-1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j -= N;
      if (elig[j]) begin
        gnt_any = 1'b1;
        gnt = IW'(j);
      end
    end
  end

  assign tq_full = (tq_cnt == QW'(TAGQ));
  assign tq_pop  = fma_out_valid & (tq_cnt != '0);
  assign tq_head = tq_mem[tq_rd];
  assign issue   = gnt_any & ~tq_full & ~rst;
  assign req_ready = issue ? (N'(1) << gnt) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= '0;
      fv_q   <= 1'b0;
      fa_q   <= '0;
      fb_q   <= '0;
      fc_q   <= '0;
      tq_wr  <= '0;
      tq_rd  <= '0;
      tq_cnt <= '0;
      err_q  <= 1'b0;
      lat_sr <= '0;
    end else begin
      fv_q   <= issue;
      lat_sr <= LAT'({lat_sr, fv_q});
      if (issue) begin
        ptr   <= (gnt == IW'(N-1)) ? '0 : gnt + 1'b1;
        fa_q  <= req_a[16*gnt +: 16];
        fb_q  <= req_b[16*gnt +: 16];
        fc_q  <= req_c[16*gnt +: 16];
        tq_wr <= (tq_wr == TP'(TAGQ-1)) ? '0 : tq_wr + 1'b1;
      end
      if (tq_pop)
        tq_rd <= (tq_rd == TP'(TAGQ-1)) ? '0 : tq_rd + 1'b1;
      if (issue & ~tq_pop)
        tq_cnt <= tq_cnt + 1'b1;
      else if (~issue & tq_pop)
        tq_cnt <= tq_cnt - 1'b1;
      if (fma_out_valid & (tq_cnt == '0))
        err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) tq_mem[tq_wr] <= gnt;
  end

  assign fma_in_valid = fv_q & ~rst;
  assign fma_a        = rst ? 16'h0 : fa_q;
  assign fma_b        = rst ? 16'h0 : fb_q;
  assign fma_c        = rst ? 16'h0 : fc_q;
  assign err_orphan   = err_q & ~rst;
  assign inflight     = rst ? '0 : tq_cnt;
  assign busy         = (inflight != '0) | (|resp_valid);

  for (genvar i = 0; i < N; i++) begin : g_port
    logic [CW-1:0] credit;
    logic [CW-1:0] cnt;
    logic [FP-1:0] wr, rd;
    logic [15:0]   mem [DEPTH];
    logic          gi;

    assign gi       = issue & (gnt == IW'(i));
    assign elig[i]  = req_valid[i] & (credit != '0);
    assign f_wen[i] = tq_pop & (tq_head == IW'(i));
    assign f_ren[i] = resp_ready[i] & (cnt != '0);

    always_ff @(posedge clk) begin
      if (rst) begin
        credit <= CW'(DEPTH);
        cnt    <= '0;
        wr     <= '0;
        rd     <= '0;
      end else begin
        if (gi & ~f_ren[i])
          credit <= credit - 1'b1;
        else if (~gi & f_ren[i])
          credit <= credit + 1'b1;
        if (f_wen[i])
          wr <= (wr == FP'(DEPTH-1)) ? '0 : wr + 1'b1;
        if (f_ren[i])
          rd <= (rd == FP'(DEPTH-1)) ? '0 : rd + 1'b1;
        if (f_wen[i] & ~f_ren[i])
          cnt <= cnt + 1'b1;
        else if (~f_wen[i] & f_ren[i])
          cnt <= cnt - 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (f_wen[i]) mem[wr] <= fma_out;
    end

    assign resp_valid[i] = ~rst & (cnt != '0);
    assign resp_data[16*i +: 16] = resp_valid[i] ? mem[rd] : 16'h0;

    a_no_ovf: assert property (@(posedge clk) disable iff (rst)
      !(f_wen[i] && !f_ren[i] && cnt == CW'(DEPTH)));
    a_credit: assert property (@(posedge clk) disable iff (rst)
      (credit <= CW'(DEPTH)) && !(gi && !f_ren[i] && credit == '0));
  end

  // a tagged return must line up with an issue exactly LAT cycles earlier
  a_lat: assert property (@(posedge clk) disable iff (rst)
    (fma_out_valid && tq_cnt != '0) |-> lat_sr[LAT-1]);

endmodule

// File: doc/fp16_fma_arbiter.md
FP16_FMA_ARBITER -- requirements
Module: fp16_fma_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter LAT, default 4: fixed FMA latency in cycles, from fma_in_valid to fma_out_valid.
REQ-003 SHALL have parameter DEPTH, default 4: per-requester result FIFO depth, which is also the credit count.
REQ-004 SHALL have parameter TAGQ, default 8: in-flight tag queue depth.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 req_valid  input  N  requester i has an operation pending.
REQ-008 req_ready  output  N  requester i is accepted this cycle.
REQ-009 req_a, req_b, req_c  input  16*N each  FP16 operands; slice i = bits [16i+15:16i].
REQ-010 resp_valid  output  N  result FIFO i is non-empty.
REQ-011 resp_ready  input  N  requester i consumes its head result.
REQ-012 resp_data  output  16*N  FP16 head result of FIFO i.
REQ-013 fma_in_valid  output  1  issue to the shared FMA.
REQ-014 fma_a, fma_b, fma_c  output  16 each  FMA operands.
REQ-015 fma_out_valid  input  1  FMA result valid.
REQ-016 fma_out  input  16  FMA result.
REQ-017 inflight  output  $clog2(TAGQ+1)  number of tag-queue entries.
REQ-018 busy  output  1  inflight != 0 or any result FIFO is non-empty.
REQ-019 err_orphan  output  1  sticky: an FMA result arrived while the tag queue was empty.

Function
REQ-020 eligible[i] SHALL equal req_valid[i] & (credit[i] != 0); an issue SHALL also require the tag queue to be non-full.
REQ-021 Grant SHALL be round-robin, at most one per cycle, searching eligible requesters from ptr upward modulo N.
REQ-022 After a grant to requester g, ptr SHALL become (g+1) mod N; with no grant, ptr SHALL hold.
REQ-023 req_ready SHALL be combinational and one-hot-or-zero, asserted only for the granted requester; the handshake completes in that same cycle.
REQ-024 On a handshake in cycle T, fma_in_valid and fma_a/b/c SHALL be registered and presented at T+1 with the granted operands; fma_in_valid SHALL be 0 otherwise.
REQ-025 fma_a/b/c SHALL hold their last values when not issuing.
REQ-026 On each issue, the granted index SHALL be pushed into an in-order tag queue of depth TAGQ.
REQ-027 On fma_out_valid, the tag queue SHALL pop; fma_out SHALL be written into result FIFO[tag] at the next edge, so resp_valid asserts at T+2+LAT (T+6 by default).
REQ-028 A push and a pop in the same cycle SHALL leave the queue occupancy unchanged.
REQ-029 fma_out_valid with an empty tag queue SHALL drop the result and set err_orphan, which stays set until rst.
REQ-030 credit[i] SHALL reset to DEPTH, decrement on a grant to i, and increment on resp_valid[i] & resp_ready[i]; both in one cycle SHALL leave it unchanged.
REQ-031 credit[i] SHALL never exceed DEPTH nor underflow.
REQ-032 Each result FIFO SHALL be first-word fall-through: resp_data[i] is the head entry whenever resp_valid[i] = 1.
REQ-033 A simultaneous write and read on a FIFO SHALL be legal at any occupancy, including full.
REQ-034 Credits SHALL guarantee that no FIFO overflows; an overflow is a design error and shall be flagged by an assertion.
REQ-035 resp_ready[i] asserted while resp_valid[i] = 0 SHALL have no effect.
REQ-036 Results SHALL be returned per requester in issue order; ordering across requesters is not guaranteed beyond issue order.
REQ-037 The block SHALL add no combinational path from the fma_* inputs to the req_* or resp_* outputs.

Reset
REQ-038 While rst is high, the block SHALL drive: req_ready=0, fma_in_valid=0, fma_a/b/c=0, resp_valid=0, resp_data=0, inflight=0, busy=0, err_orphan=0.
REQ-039 While rst is high, the block SHALL hold: ptr=0, all credits=DEPTH, tag queue and all FIFOs empty.
REQ-040 A reset mid-operation SHALL discard all in-flight and buffered results; the shared FMA is reset by the same rst.
REQ-041 The first grant after reset SHALL go to the lowest eligible index.

Verification
REQ-042 Single request, real FP16FMA: port 2 sends a=0x3C00, b=0x4000, c=0x3C00 at T -> req_ready[2]=1 at T; fma_in_valid at T+1; resp_valid[2]=1 at T+6 with resp_data=0x4200; other resp_valid stay 0.
REQ-043 All four ports hold req_valid for 8 cycles with resp_ready=1 -> grant order 0,1,2,3,0,1,2,3; one issue per cycle; every result is routed to its issuing port.
REQ-044 Port 0 requests continuously with resp_ready[0]=0 -> exactly 4 grants, then req_ready[0]=0. Raising resp_ready for one cycle -> exactly one further grant.
REQ-045 Rotation under contention: port 1 valid every cycle, port 3 valid from cycle 2 -> grants alternate 1,3,1,3; in a cycle with a grant and a response on the same port, credit is unchanged.
REQ-046 Reset mid-operation: rst for 1 cycle with 3 in flight -> inflight=0, busy=0, all credits=4; no stale resp_valid afterwards.
REQ-047 Orphan result: fma_out_valid forced with an empty queue -> result dropped, err_orphan=1 until the next rst.
